// File: rtl/led_display_scheduler.sv
// led_display_scheduler
// Time-shares the 8-bit board LED bank between four sources:
//   - a transient configuration notification, held for HOLD_CYCLES cycles
//   - the UART data debug view, selected by a board switch
//   - sticky CM/UART error flags
//   - the reset indicator (8'h80 while rst_n is low)
// A priority FSM (NOTIFY > DATA > ERROR > IDLE) chooses the source.
// Both leds and display_state are registered, so neither has a
// combinational path from any input.
module led_display_scheduler #(
    parameter int HOLD_CYCLES = 1_000_000,
    parameter int HOLD_W      = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       UART_data_debug_switch,
    input  logic [7:0] UART_data,
    input  logic       UART_data_valid,
    input  logic [3:0] CM_errors,
    input  logic       CM_errors_valid,
    input  logic [1:0] UART_errors,
    input  logic       UART_errors_valid,
    input  logic [7:0] config_notification,
    input  logic       config_notification_valid,
    input  logic       error_clear,
    output logic [7:0] leds,
    output logic [1:0] display_state
);

    // Display source, encoded exactly as it appears on display_state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ERROR  = 2'b01,
        ST_DATA   = 2'b10,
        ST_NOTIFY = 2'b11
    } state_t;

    // Value loaded into the hold counter when a notification starts. The
    // counter counts down to zero while NOTIFY is shown, so HOLD_CYCLES-1
    // gives exactly HOLD_CYCLES cycles of notification on the LEDs.
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    // LED pattern shown while the block is held in reset
    localparam logic [7:0] LEDS_RESET = 8'h80;

    // Switch synchronizer flops
    logic sw_meta_q;
    logic sw_s_q;

    // Latches and counter
    logic [5:0]        err_q,  err_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        note_q, note_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    // FSM and registered outputs
    state_t     state_q, state_d;
    state_t     base_state;
    logic [7:0] leds_q, leds_d;

    // Two-flop synchronizer for the asynchronous board switch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q <= 1'b0;
            sw_s_q    <= 1'b0;
        end else begin
            sw_meta_q <= UART_data_debug_switch;
            sw_s_q    <= sw_meta_q;
        end
    end

    // Next values of the sticky error flags and the data/notification latches
    always_comb begin
        err_d = err_q & ~{6{error_clear}};
        if (CM_errors_valid) begin
            err_d = err_d | {2'b00, CM_errors};
        end
        if (UART_errors_valid) begin
            err_d = err_d | {UART_errors, 4'b0000};
        end

        data_d = data_q;
        if (UART_data_valid) begin
            data_d = UART_data;
        end

        note_d = note_q;
        if (config_notification_valid) begin
            note_d = config_notification;
        end
    end

    // Source chosen when no notification is active. The next error value is
    // used so that the state and the LED pattern always agree in the cycle
    // after an error or clear strobe.
    always_comb begin
        base_state = ST_IDLE;
        if (sw_s_q) begin
            base_state = ST_DATA;
        end else if (err_d != 6'd0) begin
            base_state = ST_ERROR;
        end
    end

    // Priority FSM next state and hold counter; a new strobe always restarts
    // the notification, even if one is already being shown
    always_comb begin
        state_d    = base_state;
        hold_cnt_d = hold_cnt_q;
        if (config_notification_valid) begin
            state_d    = ST_NOTIFY;
            hold_cnt_d = HOLD_LOAD;
        end else if (state_q == ST_NOTIFY) begin
            if (hold_cnt_q != '0) begin
                state_d    = ST_NOTIFY;
                hold_cnt_d = hold_cnt_q - 1'b1;
            end
        end
    end

    // LED pattern for the next state, taken from the next latch values so
    // that a strobe shows up on the LEDs one cycle later
    always_comb begin
        leds_d = {1'b0, 1'b1, err_d};
        case (state_d)
            ST_NOTIFY: leds_d = note_d;
            ST_DATA:   leds_d = data_d;
            default:   leds_d = {1'b0, 1'b1, err_d};
        endcase
    end

    // Single state register for FSM, latches, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            leds_q     <= LEDS_RESET;
            err_q      <= '0;
            data_q     <= '0;
            note_q     <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            leds_q     <= leds_d;
            err_q      <= err_d;
            data_q     <= data_d;
            note_q     <= note_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign leds          = leds_q;
    assign display_state = state_q;

endmodule

// File: tb/tb_led_display_scheduler.sv
// tb_led_display_scheduler
// Directed, table-driven bench for led_display_scheduler. The main instance
// uses HOLD_CYCLES=4; a second instance with HOLD_CYCLES=1 shares the same
// inputs and is checked only in the short-hold sequence.
module tb_led_display_scheduler;

    logic       clk;
    logic       rst_n;
    logic       sw;
    logic [7:0] uart_data;
    logic       uart_data_valid;
    logic [3:0] cm_errors;
    logic       cm_errors_valid;
    logic [1:0] uart_errors;
    logic       uart_errors_valid;
    logic [7:0] note;
    logic       note_valid;
    logic       err_clear;

    logic [7:0] leds4, leds1;
    logic [1:0] state4, state1;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic       sw;
        logic [7:0] data;
        logic       data_v;
        logic [3:0] cm;
        logic       cm_v;
        logic [1:0] ue;
        logic       ue_v;
        logic [7:0] note;
        logic       note_v;
        logic       clr;
        logic [7:0] exp_leds;
        logic [1:0] exp_state;
        logic       chk_state;
    } vec_t;

    vec_t vecs[$];

    led_display_scheduler #(.HOLD_CYCLES(4), .HOLD_W(24)) dut4 (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .UART_data_debug_switch    (sw),
        .UART_data                 (uart_data),
        .UART_data_valid           (uart_data_valid),
        .CM_errors                 (cm_errors),
        .CM_errors_valid           (cm_errors_valid),
        .UART_errors               (uart_errors),
        .UART_errors_valid         (uart_errors_valid),
        .config_notification       (note),
        .config_notification_valid (note_valid),
        .error_clear               (err_clear),
        .leds                      (leds4),
        .display_state             (state4)
    );

    led_display_scheduler #(.HOLD_CYCLES(1), .HOLD_W(24)) dut1 (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .UART_data_debug_switch    (sw),
        .UART_data                 (uart_data),
        .UART_data_valid           (uart_data_valid),
        .CM_errors                 (cm_errors),
        .CM_errors_valid           (cm_errors_valid),
        .UART_errors               (uart_errors),
        .UART_errors_valid         (uart_errors_valid),
        .config_notification       (note),
        .config_notification_valid (note_valid),
        .error_clear               (err_clear),
        .leds                      (leds1),
        .display_state             (state1)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic sw_i, input logic [7:0] data_i, input logic dv_i,
        input logic [3:0] cm_i, input logic cv_i,
        input logic [1:0] ue_i, input logic uv_i,
        input logic [7:0] note_i, input logic nv_i, input logic clr_i,
        input logic [7:0] leds_i, input logic [1:0] st_i, input logic chk_i);
        vec_t v;
        v.sw = sw_i;       v.data = data_i;  v.data_v = dv_i;
        v.cm = cm_i;       v.cm_v = cv_i;
        v.ue = ue_i;       v.ue_v = uv_i;
        v.note = note_i;   v.note_v = nv_i;  v.clr = clr_i;
        v.exp_leds = leds_i; v.exp_state = st_i; v.chk_state = chk_i;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the capturing edge
    task automatic applyStimulus(input vec_t v);
        sw                = v.sw;
        uart_data         = v.data;
        uart_data_valid   = v.data_v;
        cm_errors         = v.cm;
        cm_errors_valid   = v.cm_v;
        uart_errors       = v.ue;
        uart_errors_valid = v.ue_v;
        note              = v.note;
        note_valid        = v.note_v;
        err_clear         = v.clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic sw_i);
        applyStimulus(mk(sw_i, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0));
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0));
        applyStimulus(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0));

        // Reset state
        checkOutput("reset leds", leds4, 8'h80);
        checkOutput("reset state", {6'b0, state4}, 8'h00);
        checkOutput("reset leds hold1", leds1, 8'h80);

        //                 sw data  dv cm   cv ue     uv note   nv clr leds   st  chk
        // first edge after release
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h40, 2'd0, 1));
        // sticky errors
        vecs.push_back(mk(0, 8'h00, 0, 4'h5, 1, 2'b00, 0, 8'h00, 0, 0, 8'h45, 2'd1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h45, 2'd1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h45, 2'd1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b10, 1, 8'h00, 0, 0, 8'h65, 2'd1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h65, 2'd1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h1, 1, 2'b00, 0, 8'h00, 0, 1, 8'h41, 2'd1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 1, 8'h40, 2'd0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h40, 2'd0, 1));
        // data view: switch seen three cycles after it changes
        vecs.push_back(mk(1, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h40, 2'd0, 1));
        vecs.push_back(mk(1, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h40, 2'd0, 1));
        vecs.push_back(mk(1, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h00, 2'd2, 1));
        vecs.push_back(mk(1, 8'hA5, 1, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'hA5, 2'd2, 1));
        vecs.push_back(mk(1, 8'h00, 0, 4'h8, 1, 2'b00, 0, 8'h00, 0, 0, 8'hA5, 2'd2, 1));
        vecs.push_back(mk(1, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'hA5, 2'd2, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'hA5, 2'd2, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'hA5, 2'd2, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h48, 2'd1, 1));
        // notification held exactly four cycles
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h3C, 1, 0, 8'h3C, 2'd3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h3C, 2'd3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h3C, 2'd3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h3C, 2'd3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h48, 2'd1, 1));
        // retrigger two cycles into a notification
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h3C, 1, 0, 8'h3C, 2'd3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h3C, 2'd3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'hC3, 1, 0, 8'hC3, 2'd3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'hC3, 2'd3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'hC3, 2'd3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'hC3, 2'd3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h48, 2'd1, 1));
        // errors keep accumulating underneath a notification
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b01, 1, 8'h11, 1, 0, 8'h11, 2'd3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h11, 2'd3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h11, 2'd3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h11, 2'd3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h00, 0, 0, 8'h58, 2'd1, 1));

        // Release reset mid-cycle, then run the table
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d leds", i), leds4, vecs[i].exp_leds);
            if (vecs[i].chk_state) begin
                checkOutput($sformatf("vec%0d state", i), {6'b0, state4},
                            {6'b0, vecs[i].exp_state});
            end
        end

        // HOLD_CYCLES=1: notification visible for exactly one cycle
        applyStimulus(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h5A, 1, 0, 8'h00, 2'd0, 0));
        checkOutput("hold1 note leds", leds1, 8'h5A);
        checkOutput("hold1 note state", {6'b0, state1}, 8'h03);
        idleCycle(1'b0);
        checkOutput("hold1 exit leds", leds1, 8'h58);
        checkOutput("hold1 exit state", {6'b0, state1}, 8'h01);
        checkOutput("hold4 still note", leds4, 8'h5A);
        idleCycle(1'b0);
        idleCycle(1'b0);
        idleCycle(1'b0);
        checkOutput("hold4 exit leds", leds4, 8'h58);

        // Reset in the middle of a notification
        applyStimulus(mk(0, 8'h00, 0, 4'h0, 0, 2'b00, 0, 8'h77, 1, 0, 8'h00, 2'd0, 0));
        idleCycle(1'b0);
        checkOutput("pre-reset note", leds4, 8'h77);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset leds", leds4, 8'h80);
        checkOutput("async reset state", {6'b0, state4}, 8'h00);
        idleCycle(1'b0);
        idleCycle(1'b0);
        checkOutput("held reset leds", leds4, 8'h80);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            idleCycle(1'b0);
            checkOutput($sformatf("post-reset %0d leds", k), leds4, 8'h40);
            checkOutput($sformatf("post-reset %0d state", k), {6'b0, state4}, 8'h00);
        end

        // Data latch cleared by reset: switching to the data view shows zero
        idleCycle(1'b1);
        idleCycle(1'b1);
        idleCycle(1'b1);
        checkOutput("post-reset data leds", leds4, 8'h00);
        checkOutput("post-reset data state", {6'b0, state4}, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
